tmds_serializer_multi: RTL and testbench

- Multi-channel parallel-to-serial converter for the HDMI TMDS output path, running in the serial clock domain.
- Owns its own word-phase counter and loads new words through a valid/ready handshake, so upstream needs no external write-enable timing.
- Supports 1 or 2 output bits per clock (SDR, or DDR-ready bit pairs for an output primitive).
- Substitutes a programmable idle word and flags an underflow when upstream misses a word slot.

---
 rtl/tmds_serializer_multi.sv | 86 ++++++++
 tb/tb_tmds_serializer_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tmds_serializer_multi.sv
// Multi-lane TMDS parallel-to-serial converter with a free-running word phase, valid/ready loading and idle-word underflow fill.
// Optional saturating underflow counter is enabled by defining SERIALIZER_UNDERFLOW_CNT_EN.
module tmds_serializer_multi #(
    parameter int              CHANNELS     = 3,
    parameter int              WIDTH        = 10,
    parameter int              BITS_PER_CLK = 1,
    parameter logic [WIDTH-1:0] IDLE_WORD   = 10'h354
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
    input  logic                             underflow_clr,
    output logic [15:0]                      underflow_count,
`endif
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*WIDTH-1:0]        data_in,
    output logic [CHANNELS*BITS_PER_CLK-1:0] serial_out,
    output logic                             word_start,
    output logic                             underflow
);

    localparam int SHIFTS = WIDTH / BITS_PER_CLK;
    localparam int PH_W   = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(SHIFTS - 1);

    generate
        if ((BITS_PER_CLK != 1 && BITS_PER_CLK != 2) || (WIDTH % BITS_PER_CLK != 0)) begin : g_param_check
            $error("tmds_serializer_multi: BITS_PER_CLK must be 1 or 2 and divide WIDTH");
        end
    endgenerate

    logic [PH_W-1:0]  phase;
    logic [WIDTH-1:0] lane_sr [CHANNELS];
    logic             load;

    assign load     = (phase == LAST_PHASE);
    assign in_ready = load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= LAST_PHASE;
            word_start <= 1'b0;
            underflow  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                lane_sr[c] <= '0;
            end
        end else begin
            word_start <= load;
            underflow  <= load && !in_valid;
            if (load) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
            // All lanes load together from one handshake so they can never skew.
            for (int c = 0; c < CHANNELS; c++) begin
                if (load) begin
                    lane_sr[c] <= in_valid ? data_in[c*WIDTH +: WIDTH] : IDLE_WORD;
                end else begin
                    lane_sr[c] <= lane_sr[c] >> BITS_PER_CLK;
                end
            end
        end
    end

    // LSB first: group bit 0 is the earlier bit when two bits leave per clock.
    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_lane_out
            assign serial_out[c*BITS_PER_CLK +: BITS_PER_CLK] = lane_sr[c][BITS_PER_CLK-1:0];
        end
    endgenerate

`ifdef SERIALIZER_UNDERFLOW_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_count <= '0;
        end else if (underflow_clr) begin
            underflow_count <= '0;
        end else if (load && !in_valid && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_serializer_multi.sv
// Directed bench for tmds_serializer_multi: default 3-lane SDR, a 1-lane 2-bit instance and a single-shift instance.
module tb_tmds_serializer_multi;

    localparam logic [9:0] IDLE = 10'h354;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, word_start, underflow;
    logic [29:0] data_in;
    logic [2:0]  serial_out;

    logic        in_valid2, in_ready2, word_start2, underflow2;
    logic [9:0]  data_in2;
    logic [1:0]  serial_out2;

    logic        in_valid3, in_ready3, word_start3, underflow3;
    logic [1:0]  data_in3;
    logic [1:0]  serial_out3;

`ifdef SERIALIZER_UNDERFLOW_CNT_EN
    logic        underflow_clr, underflow_clr2, underflow_clr3;
    logic [15:0] underflow_count, underflow_count2, underflow_count3;
`endif

    tmds_serializer_multi dut (
        .clk(clk), .rst(rst),
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
        .underflow_clr(underflow_clr), .underflow_count(underflow_count),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .serial_out(serial_out), .word_start(word_start), .underflow(underflow)
    );

    tmds_serializer_multi #(.CHANNELS(1), .WIDTH(10), .BITS_PER_CLK(2), .IDLE_WORD(10'h354)) dut2 (
        .clk(clk), .rst(rst),
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
        .underflow_clr(underflow_clr2), .underflow_count(underflow_count2),
`endif
        .in_valid(in_valid2), .in_ready(in_ready2), .data_in(data_in2),
        .serial_out(serial_out2), .word_start(word_start2), .underflow(underflow2)
    );

    tmds_serializer_multi #(.CHANNELS(1), .WIDTH(2), .BITS_PER_CLK(2), .IDLE_WORD(2'b10)) dut3 (
        .clk(clk), .rst(rst),
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
        .underflow_clr(underflow_clr3), .underflow_count(underflow_count3),
`endif
        .in_valid(in_valid3), .in_ready(in_ready3), .data_in(data_in3),
        .serial_out(serial_out3), .word_start(word_start3), .underflow(underflow3)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full word slot: the bench sits #1 after an edge with in_ready high.
    task automatic run_word(input logic [29:0] w, input logic v, input logic [9:0] wa, input logic [9:0] wb);
        logic [29:0] e;
        logic [1:0]  d3;
        logic [1:0]  exp2;
        e = v ? w : {IDLE, IDLE, IDLE};
        chk("ready_before_load", in_ready, 1);
        data_in   = w;
        in_valid  = v;
        data_in2  = wa;
        in_valid2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d3 = 2'($urandom);
            data_in3 = d3;
            if (k == 4) data_in2 = wb;
            @(posedge clk);
            #1;
            if (k == 0) begin
                data_in  = 30'($urandom);
                in_valid = 1'b1;
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
                underflow_clr = 1'b0;
`endif
            end
            chk("serial_out", serial_out, {e[20+k], e[10+k], e[k]});
            chk("word_start", word_start, (k == 0));
            chk("underflow", underflow, (k == 0) && !v);
            chk("in_ready", in_ready, (k == 9));
            exp2 = (k < 5) ? wa[2*k +: 2] : wb[2*(k-5) +: 2];
            chk("serial_out2", serial_out2, exp2);
            chk("word_start2", word_start2, (k == 0) || (k == 5));
            chk("in_ready2", in_ready2, (k == 4) || (k == 9));
            chk("serial_out3", serial_out3, d3);
            chk("in_ready3", in_ready3, 1);
        end
    endtask

    initial begin
        in_valid  = 1'b1; data_in  = 30'($urandom);
        in_valid2 = 1'b1; data_in2 = 10'($urandom);
        in_valid3 = 1'b1; data_in3 = 2'($urandom);
`ifdef SERIALIZER_UNDERFLOW_CNT_EN
        underflow_clr = 1'b0; underflow_clr2 = 1'b0; underflow_clr3 = 1'b0;
`endif
        // Reset held with live data on the inputs
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial_out", serial_out, 0);
        chk("rst_word_start", word_start, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_serial_out2", serial_out2, 0);
        chk("rst_in_ready2", in_ready2, 1);
        rst = 1'b0;

        run_word({10'h3FF, 10'h000, 10'h2AA}, 1'b1, 10'h0F3, 10'h2C5);
        run_word(30'h1234_5678, 1'b0, 10'h155, 10'h0F3);
        run_word(30'h2D5_A5C3, 1'b1, 10'h3FF, 10'h001);

        // Reset asserted mid-word must clear the outputs immediately
        data_in  = 30'h3FFF_FFFF; in_valid = 1'b1;
        data_in2 = 10'h3FF;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_serial_out", serial_out, 3'b111);
        rst = 1'b1;
        #1;
        chk("midrst_serial_out", serial_out, 0);
        chk("midrst_word_start", word_start, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_serial_out2", serial_out2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 100; n++) begin
            run_word(30'($urandom), 1'b1, 10'($urandom), 10'($urandom));
        end

`ifdef SERIALIZER_UNDERFLOW_CNT_EN
        chk("count_after_stream", underflow_count, 0);
        for (int n = 0; n < 3; n++) run_word(30'($urandom), 1'b0, 10'h0F3, 10'h0F3);
        chk("count_three_misses", underflow_count, 3);
        underflow_clr = 1'b1;
        run_word(30'($urandom), 1'b0, 10'h0F3, 10'h0F3);
        chk("count_clear_wins", underflow_count, 0);
        run_word(30'($urandom), 1'b0, 10'h0F3, 10'h0F3);
        chk("count_after_clear", underflow_count, 1);

        // Every edge is a load edge on dut3, so misses accrue each clock
        in_valid3 = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        chk("count3_near_sat", underflow_count3, 16'hFFFE);
        chk("underflow3_pulse", underflow3, 1);
        chk("serial_out3_idle", serial_out3, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("count3_saturated", underflow_count3, 16'hFFFF);
        underflow_clr3 = 1'b1;
        @(posedge clk);
        #1;
        underflow_clr3 = 1'b0;
        chk("count3_cleared", underflow_count3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
